// File: rtl/nes_pad_pkg.sv
// -----------------------------------------------------------------------------
// nes_pad_pkg
// Shared definitions for the NES pad emulator: register offsets, button bit
// indices, FSM state encoding and STATUS field positions.
// -----------------------------------------------------------------------------
package nes_pad_pkg;

  // Register offsets from BASE_ADDR
  localparam logic [31:0] REG_BUTTONS = 32'h0;
  localparam logic [31:0] REG_STATUS  = 32'h4;
  localparam logic [31:0] REG_TURBO   = 32'h8;

  // BUTTONS bit indices (1 = pressed); bit 7 is shifted out first
  localparam int BTN_A      = 7;
  localparam int BTN_B      = 6;
  localparam int BTN_SELECT = 5;
  localparam int BTN_START  = 4;
  localparam int BTN_UP     = 3;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_RIGHT  = 0;

  // STATUS field positions
  localparam int STAT_FRAME_LSB   = 0;   // [7:0]  frame_cnt
  localparam int STAT_BIT_CNT_LSB = 8;   // [11:8] bit_cnt
  localparam int STAT_LATCH_BIT   = 12;  // synced latch level
  localparam int STAT_OVERRUN_BIT = 13;  // sticky, write-1-to-clear

  localparam logic [3:0] BITS_PER_FRAME = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/nes_pad_emulator_if.sv
// -----------------------------------------------------------------------------
// nes_pad_emulator_if
// APB3 bus bundle for the NES pad emulator.
//   master : drives PSEL/PENABLE/PWRITE/PADDR/PWDATA, receives PRDATA/PREADY/PSLVERR
//   slave  : the peripheral side of the same signals
// -----------------------------------------------------------------------------
interface nes_pad_emulator_if;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/nes_sync_edge.sv
// -----------------------------------------------------------------------------
// nes_sync_edge
// Two-flop synchronizer followed by a registered rise/fall detector.
// An input edge shows up on rise/fall three clk cycles later.
//   clk      in  system clock
//   rst      in  asynchronous, active-high reset
//   async_in in  line asynchronous to clk
//   level    out synchronized level
//   rise     out one-cycle pulse on a synchronized rising edge
//   fall     out one-cycle pulse on a synchronized falling edge
// -----------------------------------------------------------------------------
module nes_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
      fall <= ~sync & prev;
    end
  end

  assign level = sync;

endmodule

// File: rtl/nes_pad_emulator.sv
// -----------------------------------------------------------------------------
// nes_pad_emulator
// APB3 peripheral impersonating an NES controller (4021 shift-register protocol).
// Software writes a button image; the block follows the console's latch/clock
// lines and shifts the image out on data_out, active-low.
//   PCLK     in  system clock
//   PRESERN  in  asynchronous, active-high reset
//   apb      APB3 slave (PRDATA registered, PREADY=1, PSLVERR=0)
//   latch_in in  console latch, asynchronous
//   clk_in   in  console shift clock, asynchronous
//   data_out out serial button data, 0 = pressed
// Build option: define NES_PAD_TURBO_EN to add the TURBO register at 0x8,
// which blanks the selected buttons on alternating frame-counter phases.
// -----------------------------------------------------------------------------
module nes_pad_emulator
  import nes_pad_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h40050010,
  parameter int          TURBO_SHIFT = 2
) (
  input  logic               PCLK,
  input  logic               PRESERN,
  nes_pad_emulator_if.slave  apb,
  input  logic               latch_in,
  input  logic               clk_in,
  output logic               data_out
);

  state_e      state, next_state;
  logic [7:0]  buttons;
  logic [7:0]  eff_btn;
  logic [7:0]  shreg;
  logic [3:0]  bit_cnt;
  logic [7:0]  frame_cnt;
  logic        overrun;
  logic [31:0] prdata;
  logic [31:0] rdata_mux;

  logic latch_lvl, latch_rise, latch_fall;
  logic sclk_rise;

  logic load_sh, shift_en, clear_cnt, frame_inc, overrun_set, dout_next;

  nes_sync_edge u_latch_sync (
    .clk(PCLK), .rst(PRESERN), .async_in(latch_in),
    .level(latch_lvl), .rise(latch_rise), .fall(latch_fall)
  );

  // Only the rising edge of the console clock matters; level and fall are unused.
  logic sclk_lvl_unused, sclk_fall_unused;
  nes_sync_edge u_clk_sync (
    .clk(PCLK), .rst(PRESERN), .async_in(clk_in),
    .level(sclk_lvl_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  // ---------------------------------------------------------------- APB decode
  wire wr_en      = apb.PSEL & apb.PENABLE & apb.PWRITE;
  wire rd_en      = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
  wire hit_button = (apb.PADDR == BASE_ADDR + REG_BUTTONS);
  wire hit_status = (apb.PADDR == BASE_ADDR + REG_STATUS);

  wire overrun_clr = wr_en & hit_status & apb.PWDATA[STAT_OVERRUN_BIT];

  wire [31:0] status_word = {18'd0, overrun, latch_lvl, bit_cnt, frame_cnt};

`ifdef NES_PAD_TURBO_EN
  logic [7:0] turbo;
  wire        hit_turbo = (apb.PADDR == BASE_ADDR + REG_TURBO);
  wire        phase     = frame_cnt[TURBO_SHIFT];

  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN)                turbo <= '0;
    else if (wr_en & hit_turbo) turbo <= apb.PWDATA[7:0];
  end

  assign eff_btn = buttons & ~(turbo & {8{phase}});
`else
  assign eff_btn = buttons;
`endif

  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN)                 buttons <= '0;
    else if (wr_en & hit_button) buttons <= apb.PWDATA[7:0];
  end

  always_comb begin
    rdata_mux = '0;
    if (hit_button)      rdata_mux = {24'd0, buttons};
    else if (hit_status) rdata_mux = status_word;
`ifdef NES_PAD_TURBO_EN
    else if (hit_turbo)  rdata_mux = {24'd0, turbo};
`endif
  end

  // Loaded during the setup phase so the data is stable in the access phase.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN)    prdata <= '0;
    else if (rd_en) prdata <= rdata_mux;
  end

  assign apb.PRDATA  = prdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  // ---------------------------------------------------------------------- FSM
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) state <= IDLE;
    else         state <= next_state;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state  = state;
    load_sh     = 1'b0;
    shift_en    = 1'b0;
    clear_cnt   = 1'b0;
    frame_inc   = 1'b0;
    overrun_set = 1'b0;
    dout_next   = 1'b1;
    case (state)
      IDLE: begin
        if (latch_rise) next_state = LOAD;
      end
      LOAD: begin
        // Parallel mode: keep reloading, console clock edges are ignored.
        load_sh   = 1'b1;
        clear_cnt = 1'b1;
        dout_next = ~shreg[7];
        if (latch_fall) begin
          frame_inc  = 1'b1;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        dout_next = ~shreg[7];
        // A latch edge in the same cycle as a clock edge wins; the clock is dropped.
        if (latch_rise) begin
          next_state = LOAD;
        end else if (sclk_rise) begin
          shift_en = 1'b1;
          if (bit_cnt == BITS_PER_FRAME - 4'd1) next_state = DONE;
        end
      end
      DONE: begin
        dout_next = 1'b0;
        if (latch_rise)     next_state  = LOAD;
        else if (sclk_rise) overrun_set = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // ----------------------------------------------------------------- datapath
  // NOTE: every flop here is a control/status register with a defined reset
  // value; there is no memory array, so nothing is left unreset.
  always_ff @(posedge PCLK or posedge PRESERN) begin
    if (PRESERN) begin
      shreg     <= '0;
      bit_cnt   <= '0;
      frame_cnt <= '0;
      overrun   <= 1'b0;
      data_out  <= 1'b1;
    end else begin
      if (load_sh)       shreg <= eff_btn;
      else if (shift_en) shreg <= {shreg[6:0], 1'b0};

      if (clear_cnt)     bit_cnt <= '0;
      else if (shift_en) bit_cnt <= bit_cnt + 4'd1;

      if (frame_inc) frame_cnt <= frame_cnt + 8'd1;

      // A set in the same cycle as a clear keeps the flag.
      if (overrun_set)      overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;

      data_out <= dout_next;
    end
  end

endmodule

// File: tb/tb_nes_pad_emulator.sv
// -----------------------------------------------------------------------------
// tb_nes_pad_emulator
// Self-checking bench for nes_pad_emulator. The reference model tracks the
// button image, frame count and overrun flag and derives the expected serial
// bits straight from the protocol: before the k-th clock the pad shows the
// inverse of button bit 7-k, and 0 once all eight have gone out.
// Honors NES_PAD_TURBO_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_nes_pad_emulator;

  localparam logic [31:0] BASE        = 32'h40050010;
  localparam int          TURBO_SHIFT = 0;
  localparam int          HALF        = 8;   // console half-period in PCLK cycles

  localparam logic [31:0] A_BUTTONS = BASE + 32'h0;
  localparam logic [31:0] A_STATUS  = BASE + 32'h4;
  localparam logic [31:0] A_TURBO   = BASE + 32'h8;

  logic PCLK;
  logic PRESERN;
  logic latch_in;
  logic clk_in;
  logic data_out;

  nes_pad_emulator_if apb ();

  nes_pad_emulator #(.BASE_ADDR(BASE), .TURBO_SHIFT(TURBO_SHIFT)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .apb(apb),
    .latch_in(latch_in), .clk_in(clk_in), .data_out(data_out)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] m_buttons;
  logic [7:0] m_turbo;
  int         m_frames;
  logic       m_overrun;

  function automatic logic [7:0] eff_btn_model();
`ifdef NES_PAD_TURBO_EN
    if (((m_frames >> TURBO_SHIFT) & 1) == 1) return m_buttons & ~m_turbo;
    return m_buttons;
`else
    return m_buttons;
`endif
  endfunction

  function automatic logic [31:0] status_model(input int bits, input logic latch_lvl);
    logic [31:0] s;
    s = '0;
    s[7:0]  = m_frames[7:0];
    s[11:8] = bits[3:0];
    s[12]   = latch_lvl;
    s[13]   = m_overrun;
    return s;
  endfunction

  function automatic void model_reset();
    m_buttons = '0;
    m_turbo   = '0;
    m_frames  = 0;
    m_overrun = 1'b0;
  endfunction

  // ------------------------------------------------------------ bus / pad BFM
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = addr; apb.PWDATA = data;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = addr;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    data = apb.PRDATA;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
  endtask

  task automatic latch_pulse();
    latch_in = 1'b1; wait_cycles(HALF);
    latch_in = 1'b0; wait_cycles(HALF);
  endtask

  task automatic clk_pulse();
    clk_in = 1'b1; wait_cycles(HALF);
    clk_in = 1'b0; wait_cycles(HALF);
  endtask

  // Checks bits first..first+count-1 of a frame, each sampled before its clock.
  task automatic shift_check(input logic [7:0] frame, input int first, input int count,
                             input string tag);
    logic exp_bit;
    for (int k = first; k < first + count; k++) begin
      exp_bit = (k < 8) ? ~frame[7-k] : 1'b0;
      checks++;
      if (data_out !== exp_bit) begin
        failures++;
        $display("FAIL %s bit%0d: data_out=%b expected=%b", tag, k, data_out, exp_bit);
      end
      clk_pulse();
      if (k >= 8) m_overrun = 1'b1;
    end
  endtask

  task automatic run_frame(input int nclk, input string tag);
    logic [7:0]  frame;
    logic [31:0] rd, exp;
    logic        exp_bit;
    frame = eff_btn_model();
    latch_pulse();
    m_frames++;
    shift_check(frame, 0, nclk, tag);
    exp_bit = (nclk >= 8) ? 1'b0 : ~frame[7-nclk];
    checks++;
    if (data_out !== exp_bit) begin
      failures++;
      $display("FAIL %s tail: data_out=%b expected=%b", tag, data_out, exp_bit);
    end
    apb_read(A_STATUS, rd);
    exp = status_model((nclk > 8) ? 8 : nclk, 1'b0);
    checks++;
    if (rd !== exp) begin
      failures++;
      $display("FAIL %s status: read=%h expected=%h", tag, rd, exp);
    end
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    logic [31:0] rd;
    PRESERN = 1'b1;
    wait_cycles(3);
    PRESERN = 1'b0;
    model_reset();
    wait_cycles(2);
    checks++;
    if (data_out !== 1'b1) begin
      failures++; $display("FAIL reset data_out: got=%b expected=1", data_out);
    end
    checks++;
    if (apb.PRDATA !== 32'h0) begin
      failures++; $display("FAIL reset PRDATA: got=%h expected=0", apb.PRDATA);
    end
    apb_read(A_BUTTONS, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset BUTTONS: got=%h expected=0", rd); end
    apb_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset STATUS: got=%h expected=0", rd); end
    apb_read(A_TURBO, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL reset TURBO: got=%h expected=0", rd); end
  endtask

  task automatic test_basic_frame();
    logic [31:0] rd;
    m_buttons = 8'h81;
    apb_write(A_BUTTONS, 32'h81);
    apb_read(A_BUTTONS, rd);
    checks++;
    if (rd !== 32'h81) begin failures++; $display("FAIL buttons readback: got=%h expected=81", rd); end
    run_frame(8, "basic");
  endtask

  task automatic test_mid_frame_write();
    logic [7:0] frame;
    m_buttons = 8'h81;
    apb_write(A_BUTTONS, 32'h81);
    frame = eff_btn_model();
    latch_pulse();
    m_frames++;
    shift_check(frame, 0, 3, "midwr_pre");
    m_buttons = 8'hFF;
    apb_write(A_BUTTONS, 32'hFF);
    shift_check(frame, 3, 5, "midwr_post");
    checks++;
    if (data_out !== 1'b0) begin
      failures++; $display("FAIL midwr done: data_out=%b expected=0", data_out);
    end
    run_frame(8, "midwr_next");
  endtask

  task automatic test_overrun();
    logic [31:0] rd, exp;
    m_buttons = 8'($urandom);
    apb_write(A_BUTTONS, {24'd0, m_buttons});
    run_frame(9, "overrun");
    apb_write(A_STATUS, 32'h2000);
    m_overrun = 1'b0;
    apb_read(A_STATUS, rd);
    exp = status_model(8, 1'b0);
    checks++;
    if (rd !== exp) begin
      failures++; $display("FAIL overrun clear: read=%h expected=%h", rd, exp);
    end
  endtask

  task automatic test_latch_high_clock();
    logic [31:0] rd, exp;
    logic [7:0]  frame;
    latch_in = 1'b1;
    wait_cycles(HALF);
    m_buttons = 8'($urandom);
    apb_write(A_BUTTONS, {24'd0, m_buttons});
    wait_cycles(4);
    frame = eff_btn_model();
    checks++;
    if (data_out !== ~frame[7]) begin
      failures++; $display("FAIL latchhi track1: data_out=%b expected=%b", data_out, ~frame[7]);
    end
    clk_pulse();
    apb_read(A_STATUS, rd);
    exp = status_model(0, 1'b1);
    checks++;
    if (rd !== exp) begin
      failures++; $display("FAIL latchhi status: read=%h expected=%h", rd, exp);
    end
    m_buttons = m_buttons ^ 8'h80;
    apb_write(A_BUTTONS, {24'd0, m_buttons});
    wait_cycles(4);
    frame = eff_btn_model();
    checks++;
    if (data_out !== ~frame[7]) begin
      failures++; $display("FAIL latchhi track2: data_out=%b expected=%b", data_out, ~frame[7]);
    end
    latch_in = 1'b0;
    m_frames++;
    wait_cycles(HALF);
    shift_check(frame, 0, 8, "latchhi_frame");
  endtask

  task automatic test_random_frames();
    int nclk;
    for (int f = 0; f < 8; f++) begin
      m_buttons = 8'($urandom);
      apb_write(A_BUTTONS, {24'd0, m_buttons});
      nclk = $urandom_range(0, 10);
      run_frame(nclk, $sformatf("rand%0d", f));
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    logic [31:0] addrs [3];
    addrs[0] = BASE + 32'hC;
    addrs[1] = BASE + 32'h100;
    addrs[2] = BASE - 32'h4;
    m_buttons = 8'h5A;
    apb_write(A_BUTTONS, 32'h5A);
    for (int i = 0; i < 3; i++) begin
      apb_write(addrs[i], 32'hFFFF_FFFF);
      apb_read(addrs[i], rd);
      checks++;
      if (rd !== 32'h0) begin
        failures++; $display("FAIL unmapped read %h: got=%h expected=0", addrs[i], rd);
      end
    end
    apb_read(A_BUTTONS, rd);
    checks++;
    if (rd !== 32'h5A) begin
      failures++; $display("FAIL unmapped write leak: BUTTONS=%h expected=5a", rd);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    m_buttons = 8'h00;
    apb_write(A_BUTTONS, 32'h00);
    latch_pulse();
    clk_pulse();
    clk_pulse();
    // data_out is 1 here for an empty image, so press A to make reset visible
    apb_write(A_BUTTONS, 32'hFF);
    latch_pulse();
    PRESERN = 1'b1;
    #1;
    model_reset();
    checks++;
    if (data_out !== 1'b1) begin
      failures++; $display("FAIL rstmid data_out: got=%b expected=1", data_out);
    end
    wait_cycles(2);
    PRESERN = 1'b0;
    clk_pulse();
    checks++;
    if (data_out !== 1'b1) begin
      failures++; $display("FAIL rstmid idle clk: data_out=%b expected=1", data_out);
    end
    apb_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL rstmid STATUS: got=%h expected=0", rd); end
  endtask

  task automatic test_turbo();
    logic [31:0] rd;
`ifdef NES_PAD_TURBO_EN
    m_turbo = 8'h80;
    apb_write(A_TURBO, 32'h80);
    apb_read(A_TURBO, rd);
    checks++;
    if (rd !== 32'h80) begin failures++; $display("FAIL turbo readback: got=%h expected=80", rd); end
`else
    apb_write(A_TURBO, 32'hFF);
    apb_read(A_TURBO, rd);
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL turbo absent: got=%h expected=0", rd); end
`endif
    m_buttons = 8'h80;
    apb_write(A_BUTTONS, 32'h80);
    for (int f = 0; f < 4; f++) run_frame(8, $sformatf("turbo%0d", f));
  endtask

  initial begin
    PRESERN     = 1'b1;
    latch_in    = 1'b0;
    clk_in      = 1'b0;
    apb.PSEL    = 1'b0;
    apb.PENABLE = 1'b0;
    apb.PWRITE  = 1'b0;
    apb.PADDR   = '0;
    apb.PWDATA  = '0;
    model_reset();

    test_reset();
    test_basic_frame();
    test_mid_frame_write();
    test_overrun();
    test_latch_high_clock();
    test_random_frames();
    test_unmapped();
    test_reset_mid_frame();
    test_turbo();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nes_pad_emulator.md
# nes_pad_emulator

APB3 peripheral that impersonates an NES controller toward an external console or reader. Software writes a button image over APB. The block samples the external `latch_in` and `clk_in` lines and serially drives `data_out`, following the 4021 shift-register protocol that our controller reader consumes. It sits on the same APB3 bus as the controller reader and is used for loopback test and for driving a second console.

## Interface
Parameters:
- BASE_ADDR, 32'h40050010, full 32-bit APB base address of the register window.
- TURBO_SHIFT, 2, frame-counter bit selecting the turbo phase; only used with the macro.

Ports:
- PCLK  in  1  system clock; the only clock.
- PRESERN  in  1  reset, asynchronous, active-high (1 = reset asserted).
- PSEL, PENABLE, PWRITE  in  1  APB3 control.
- PADDR  in  32  APB3 address.
- PWDATA  in  32  APB3 write data.
- PRDATA  out  32  APB3 read data, registered.
- PREADY  out  1  tied 1.
- PSLVERR  out  1  tied 0.
- latch_in  in  1  console latch; asynchronous to PCLK.
- clk_in  in  1  console shift clock; asynchronous to PCLK.
- data_out  out  1  serial button data, active-low (0 = pressed).

## Operation
- Registers are offsets from BASE_ADDR.
  - 0x0 BUTTONS, RW, bits [7:0], 1 = pressed. Bit order: 7 A, 6 B, 5 Select, 4 Start, 3 Up, 2 Down, 1 Left, 0 Right.
  - 0x4 STATUS:
    - [7:0] frame_cnt, RO: increments on each latch falling edge and wraps from 255 to 0.
    - [11:8] bit_cnt, RO: range 0..8.
    - [12] synced latch level, RO.
    - [13] overrun, W1C: sticky, set by a `clk_in` rising edge while in DONE.
    - Other bits read as 0.
  - 0x8 TURBO: exists only with the macro (see Configuration).
  - Any unmapped address reads 0; writes to it are ignored.
- Write strobe: PSEL & PENABLE & PWRITE & address match. Read: PRDATA is loaded when PSEL & ~PENABLE & ~PWRITE, so it is valid in the access phase.
- `latch_in` and `clk_in` each pass through a 2-flop synchronizer followed by an edge detector.
- eff_btn equals BUTTONS, masked by turbo when the macro is enabled.
- State machine:
  - IDLE: entered at reset. data_out = 1. A latch rising edge moves to LOAD.
  - LOAD (latch high):
    - shreg <= eff_btn every cycle.
    - bit_cnt = 0.
    - data_out = ~shreg[7].
    - `clk_in` edges are ignored (parallel mode).
    - Latch falling edge: frame_cnt increments, then go to SHIFT.
  - SHIFT:
    - data_out = ~shreg[7].
    - Each `clk_in` rising edge: shreg <= {shreg[6:0],1'b0} and bit_cnt increments.
    - When bit_cnt reaches 8, go to DONE.
  - DONE: data_out = 0. A `clk_in` rising edge sets overrun.
  - From SHIFT or DONE, a latch rising edge goes to LOAD.
- A BUTTONS write during SHIFT or DONE does not affect the frame in flight. A write during LOAD takes effect the following cycle.
- If a latch rising edge and a clock rising edge occur in the same cycle, the latch wins and the clock edge is dropped.

## Timing
- Input edge to internal action: 3 PCLK cycles (2 synchronizer stages plus the edge register). data_out is registered and updates 1 cycle after the action.
- The external clock half-period must be at least 4 PCLK cycles; shorter pulses are unsupported.
- Reset values: PRDATA 0, data_out 1, state IDLE, all registers 0.
- Assertion of PRESERN mid-frame returns the block immediately to IDLE with data_out 1.
- APB access completes with zero wait states.

## Configuration
- Macro: NES_PAD_TURBO_EN.
- Defined:
  - Register 0x8 TURBO is RW, bits [7:0].
  - phase = frame_cnt[TURBO_SHIFT].
  - eff_btn = BUTTONS & ~(TURBO & {8{phase}}).
- Undefined:
  - eff_btn = BUTTONS.
  - 0x8 is unmapped: reads 0, writes are ignored.
  - No turbo register is implemented.

## Structure
- Package nes_pad_pkg holds:
  - register offsets,
  - button bit indices,
  - the state enum (IDLE, LOAD, SHIFT, DONE),
  - the STATUS field positions.
- Sub-module nes_sync_edge: 2-flop synchronizer plus registered rise/fall detector. It is instantiated twice, once for `latch_in` and once for `clk_in`.

## Test plan
- Reset, then read all registers: every register is 0 and data_out = 1.
- Write BUTTONS = 0x81, pulse latch, then 8 clock pulses:
  - data_out sampled before each clock edge reads 0,1,1,1,1,1,1,0.
  - data_out is 0 afterwards.
  - STATUS reads 0x0801.
- Write BUTTONS = 0x81, latch, 3 clocks, write 0xFF, 5 more clocks:
  - the remaining bits are 1,1,1,1,0 (the old frame).
  - the next frame outputs 0 for all eight bits.
- A 9th clock pulse sets STATUS[13]. Writing 0x2000 to STATUS clears it; frame_cnt is unchanged.
- A clock pulse while latch is high is ignored: bit_cnt = 0 and data_out tracks BUTTONS[7]. Assert PRESERN during SHIFT: data_out = 1 and state is IDLE.
- With NES_PAD_TURBO_EN and TURBO_SHIFT = 0, TURBO = BUTTONS = 0x80: the first data_out bit alternates 0/1 across consecutive frames. Without the macro, a read of 0x8 returns 0 and every frame outputs 0.
